// File: rtl/piso_frame_ctrl_pkg.sv
// Shared definitions for the PISO frame sequencer: FSM encoding and sizing.
package piso_frame_ctrl_pkg;

  localparam int PISO_WIDTH = 12;
  localparam int GAP_CNT_W  = 4;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int PISO_CNT_W = cnt_width(PISO_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/piso_frame_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant, only while enabled
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = last_grant ? 2'b01 : 2'b10;
      else if (req[0])      gnt = 2'b01;
      else if (req[1])      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/piso_frame_ctrl.sv
// Load/shift sequencer and 2-way arbiter for a PISO shift register, with frame strobes
// aligned to the register's serial output.
module piso_frame_ctrl
  import piso_frame_ctrl_pkg::*;
#(
  parameter int WIDTH      = PISO_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             piso_sl,
  output logic [WIDTH-1:0] piso_data,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_ch,
  output logic             busy
);

  localparam int                   CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [WIDTH-1:0]     hold;
  logic                 hold_ch;
  logic                 last_grant;
  logic                 shift_last, gap_last, accept, hs;
  logic [1:0]           gnt;

  assign shift_last = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign gap_last   = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  // No word is taken while reset is held, so nothing presented during reset is lost.
  assign accept     = !rst && ((state == ST_IDLE) || (shift_last && !HAS_GAP) || gap_last);

  rr_arb2 u_arb (
    .en         (accept),
    .req        ({in1_valid, in0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];
  assign hs        = |gnt;
  // Busy covers the trailing frame_end cycle after the FSM has already returned to IDLE.
  assign busy      = (state != ST_IDLE) || frame_end;

  // Next-state and load-side outputs
  always_comb begin
    state_nxt = state;
    piso_sl   = 1'b0;
    piso_data = '0;
    case (state)
      ST_IDLE:  if (hs) state_nxt = ST_LOAD;
      ST_LOAD: begin
        piso_sl   = 1'b1;
        piso_data = hold;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_last) begin
          if (HAS_GAP) state_nxt = ST_GAP;
          else         state_nxt = hs ? ST_LOAD : ST_IDLE;
        end
      end
      ST_GAP:   if (gap_last) state_nxt = hs ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Shift and gap counters, cleared whenever their state is not active
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      cnt     <= (state == ST_SHIFT && !shift_last) ? cnt + CNT_W'(1) : '0;
      gap_cnt <= (state == ST_GAP && !gap_last) ? gap_cnt + GAP_CNT_W'(1) : '0;
    end
  end

  // Arbitration history and channel of the held word
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      hold_ch    <= 1'b0;
    end else if (hs) begin
      last_grant <= gnt[1];
      hold_ch    <= gnt[1];
    end
  end

  // Hold register for the accepted word
  always_ff @(posedge clk) begin
    if (hs) hold <= gnt[1] ? in1_data : in0_data;
  end

  // Strobes delayed one cycle to line up with the register's serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_ch    <= 1'b0;
    end else begin
      bit_valid   <= (state == ST_SHIFT);
      frame_start <= (state == ST_SHIFT) && (cnt == '0);
      frame_end   <= shift_last;
      if ((state == ST_SHIFT) && (cnt == '0)) frame_ch <= hold_ch;
    end
  end

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Directed bench for piso_frame_ctrl with a shift-register model and a frame scoreboard.
module tb_piso_frame_ctrl;

  localparam int W = 12;

  typedef struct {
    logic [W-1:0] data;
    logic         ch;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic [W-1:0] in0_data, in1_data, piso_data;
  logic         piso_sl, bit_valid, frame_start, frame_end, frame_ch, busy;

  logic         g_valid, g_ready, g_in1_valid, g_in1_ready;
  logic [W-1:0] g_data, g_in1_data, g_piso_data;
  logic         g_sl, g_bit_valid, g_fs, g_fe, g_ch, g_busy;

  piso_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .piso_sl(piso_sl), .piso_data(piso_data), .bit_valid(bit_valid),
    .frame_start(frame_start), .frame_end(frame_end), .frame_ch(frame_ch), .busy(busy)
  );

  piso_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst),
    .in0_valid(g_valid), .in0_data(g_data), .in0_ready(g_ready),
    .in1_valid(g_in1_valid), .in1_data(g_in1_data), .in1_ready(g_in1_ready),
    .piso_sl(g_sl), .piso_data(g_piso_data), .bit_valid(g_bit_valid),
    .frame_start(g_fs), .frame_end(g_fe), .frame_ch(g_ch), .busy(g_busy)
  );

  // Shift register model: load on SL, otherwise shift LSB out to a registered serial_out
  logic [W-1:0] sr;
  logic         serial;
  always @(posedge clk) begin
    if (piso_sl) sr <= piso_data;
    else begin
      serial <= sr[0];
      sr     <= {1'b0, sr[W-1:1]};
    end
  end

  int checks = 0, passed = 0;
  int cyc = 0, last_load = 0, last_fe = -100, bitpos = 0, rdy_cnt = 0, fe_total = 0;
  int g_run = 0, g_max = 0, g_bits = 0, g_fs_cnt = 0, g_fe_cnt = 0;
  logic inframe = 1'b0, exp_ch = 1'b0, prev_hs = 1'b0, hs0, hs1, g_hs;
  logic [W-1:0] word;
  logic [W-1:0] src0[$], src1[$], g_src[$], g_exp[$];
  exp_t sb[$];
  int load_q[$], fsgap_q[$], g_load_q[$];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    in0_valid   = (src0.size() > 0);
    in0_data    = in0_valid ? src0[0] : '0;
    in1_valid   = (src1.size() > 0);
    in1_data    = in1_valid ? src1[0] : '0;
    g_valid     = (g_src.size() > 0);
    g_data      = g_valid ? g_src[0] : '0;
    g_in1_valid = 1'b0;
    g_in1_data  = '0;
  endtask

  // One clock: monitor on the falling edge, advance sources just after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    hs0 = in0_valid && in0_ready;
    hs1 = in1_valid && in1_ready;
    chk_b("ready_onehot", in0_ready & in1_ready, 1'b0);
    chk_b("load_follows_hs", piso_sl, prev_hs);
    if (in0_ready || in1_ready) rdy_cnt++;
    if (piso_sl) begin
      load_q.push_back(cyc);
      last_load = cyc;
    end
    if (bit_valid) begin
      if (frame_start) begin
        chk_n("start_latency", cyc - last_load, 2);
        fsgap_q.push_back(cyc - last_fe);
        inframe = 1'b1;
        bitpos  = 0;
        word    = '0;
        exp_ch  = (sb.size() > 0) ? sb[0].ch : 1'b0;
      end
      chk_b("bit_in_frame", inframe, 1'b1);
      word = word | (W'(serial) << bitpos);
      bitpos++;
      chk_b("frame_ch_hold", frame_ch, exp_ch);
      if (frame_end) begin
        fe_total++;
        chk_n("bits_per_frame", bitpos, W);
        chk_b("end_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk_n("frame_word", 32'(word), 32'(e.data));
          chk_b("frame_ch", frame_ch, e.ch);
        end
        inframe = 1'b0;
        last_fe = cyc;
      end
    end else begin
      chk_b("strobe_without_valid", frame_start | frame_end, 1'b0);
    end
    prev_hs = hs0 | hs1;
    if (rst) begin
      inframe = 1'b0;
      bitpos  = 0;
    end
    g_hs = g_valid && g_ready;
    chk_b("g_in1_ready", g_in1_ready, 1'b0);
    if (g_sl) begin
      g_load_q.push_back(cyc);
      chk_b("g_load_expected", g_exp.size() > 0, 1'b1);
      if (g_exp.size() > 0) chk_n("g_load_data", 32'(g_piso_data), 32'(g_exp.pop_front()));
    end
    if (g_busy) g_run++;
    else        g_run = 0;
    if (g_run > g_max) g_max = g_run;
    if (g_bit_valid) begin
      g_bits++;
      chk_b("g_frame_ch", g_ch, 1'b0);
    end
    if (g_fs) g_fs_cnt++;
    if (g_fe) g_fe_cnt++;
    @(posedge clk);
    #1;
    if (hs0 && src0.size() > 0) src0.delete(0);
    if (hs1 && src1.size() > 0) src1.delete(0);
    if (g_hs && g_src.size() > 0) g_src.delete(0);
    drive();
  endtask

  task automatic drain(input int max, input string tag);
    int n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && g_src.size() == 0 &&
             sb.size() == 0 && !busy && !g_busy) && n < max) begin
      tick();
      n++;
    end
    chk_b({tag, "_drain"}, n < max, 1'b1);
  endtask

  initial begin
    int   fe_snap;
    logic found;
    rst = 1'b1;
    drive();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk_b("rst_piso_sl", piso_sl, 1'b0);
    chk_n("rst_piso_data", 32'(piso_data), 32'h0);
    chk_b("rst_bit_valid", bit_valid, 1'b0);
    chk_b("rst_frame_start", frame_start, 1'b0);
    chk_b("rst_frame_end", frame_end, 1'b0);
    chk_b("rst_frame_ch", frame_ch, 1'b0);
    chk_b("rst_busy", busy, 1'b0);

    // Single frame from in0
    src0.push_back(12'hA5C);
    sb.push_back('{data: 12'hA5C, ch: 1'b0});
    drive();
    drain(40, "single");
    chk_n("single_ready_count", rdy_cnt, 1);

    // Back-to-back frames with no gap
    src0.push_back(12'h001);
    src0.push_back(12'hFFF);
    sb.push_back('{data: 12'h001, ch: 1'b0});
    sb.push_back('{data: 12'hFFF, ch: 1'b0});
    drive();
    drain(60, "b2b");
    chk_n("b2b_loads", load_q.size(), 3);
    if (load_q.size() >= 3) chk_n("b2b_load_spacing", load_q[2] - load_q[1], W + 1);
    if (fsgap_q.size() >= 3) chk_n("b2b_one_bubble", fsgap_q[2], 2);

    // Both requesters valid straight out of reset
    rst = 1'b1;
    src0.push_back(12'h111);
    src0.push_back(12'h222);
    src1.push_back(12'h333);
    src1.push_back(12'h444);
    sb.push_back('{data: 12'h111, ch: 1'b0});
    sb.push_back('{data: 12'h333, ch: 1'b1});
    sb.push_back('{data: 12'h222, ch: 1'b0});
    sb.push_back('{data: 12'h444, ch: 1'b1});
    drive();
    repeat (2) tick();
    rst = 1'b0;
    drain(100, "arb");
    chk_n("arb_loads", load_q.size(), 7);
    for (int i = 4; i < 7 && i < load_q.size(); i++)
      chk_n("arb_load_spacing", load_q[i] - load_q[i-1], W + 1);
    chk_n("arb_ready_count", rdy_cnt, 7);

    // Gap instance: two queued words
    g_src.push_back(12'h5A5);
    g_src.push_back(12'h0F0);
    g_exp.push_back(12'h5A5);
    g_exp.push_back(12'h0F0);
    drive();
    drain(80, "gap");
    chk_n("gap_loads", g_load_q.size(), 2);
    if (g_load_q.size() >= 2) chk_n("gap_load_spacing", g_load_q[1] - g_load_q[0], W + 4);
    chk_n("gap_busy_run", g_max, 2 * (W + 4));
    chk_n("gap_bits", g_bits, 2 * W);
    chk_n("gap_starts", g_fs_cnt, 2);
    chk_n("gap_ends", g_fe_cnt, 2);

    // Reset during bit 5 of a frame
    src0.push_back(12'hC3A);
    sb.push_back('{data: 12'hC3A, ch: 1'b0});
    drive();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bit_valid && inframe && bitpos == 5) found = 1'b1;
    end
    chk_b("abort_reached_bit5", found, 1'b1);
    rst = 1'b1;
    tick();
    chk_b("abort_bit_valid", bit_valid, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_piso_sl", piso_sl, 1'b0);
    chk_b("abort_frame_end", frame_end, 1'b0);
    rst = 1'b0;
    sb.delete();
    fe_snap = fe_total;
    repeat (16) tick();
    chk_n("abort_no_frame_end", fe_total, fe_snap);

    // After reset, in0 wins the tie and both words serialise
    src0.push_back(12'h9B6);
    src1.push_back(12'h6D2);
    sb.push_back('{data: 12'h9B6, ch: 1'b0});
    sb.push_back('{data: 12'h6D2, ch: 1'b1});
    drive();
    drain(80, "post_rst");
    chk_n("post_rst_loads", load_q.size(), 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
